// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-port scan controller: FSM states and default sweep window.
package dbg_pkg;

  localparam int STATE_W = 3;

  localparam int DEF_SCAN_FIRST = 0;
  localparam int DEF_SCAN_LAST  = 127;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_PUSH   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// Single-register rising-edge detector producing a one-cycle pulse.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= sig_i;
  end

  assign pulse_o = sig_i & ~prev_q;

endmodule

// File: rtl/debug_scan_ctrl.sv
// Host-side debug port controller: step pulses, address sweep, {addr,data} valid/ready stream.
// Optional DEBUG_SCAN_CHECKSUM_EN adds a per-sweep sum of accepted data (scan_sum/sum_valid).
module debug_scan_ctrl
  import dbg_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int SCAN_FIRST = DEF_SCAN_FIRST,
  parameter int SCAN_LAST  = DEF_SCAN_LAST,
  parameter int SETTLE     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_mode,
  input  logic              step_req,
  input  logic              scan_req,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              scan_done
`ifdef DEBUG_SCAN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] scan_sum,
  output logic              sum_valid
`endif
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(SCAN_FIRST);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(SCAN_LAST);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic                ovld_q, ovld_d;
  logic                step_q, step_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic                pend_q, pend_d;
  logic                pend_step_q, pend_step_d;
  logic                step_pulse;
  logic                edge_ok;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                sum_vld_q, sum_vld_d;
`endif

  edge_detect u_step_edge (
    .clk_i   (clk),
    .rst_ni  (rst),
    .sig_i   (step_req),
    .pulse_o (step_pulse)
  );

  assign edge_ok = step_pulse & ~run_mode;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    oaddr_d     = oaddr_q;
    odata_d     = odata_q;
    ovld_d      = ovld_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    en_d        = ~run_mode;
    pend_d      = pend_q;
    pend_step_d = pend_step_q;
`ifdef DEBUG_SCAN_CHECKSUM_EN
    sum_d       = sum_q;
    sum_vld_d   = 1'b0;
`endif

    // Requests arriving mid-sweep are remembered once; a step outranks a scan.
    if (state_q != ST_IDLE && !pend_q && (edge_ok || scan_req)) begin
      pend_d      = 1'b1;
      pend_step_d = edge_ok;
    end

    case (state_q)
      ST_IDLE: begin
        if (edge_ok || (pend_q && pend_step_q && !run_mode)) begin
          state_d = ST_STEP;
          step_d  = 1'b1;
          pend_d  = 1'b0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
          sum_d   = '0;
`endif
        end else if (scan_req || pend_q) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_STEP: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_SAMPLE: begin
        oaddr_d = addr_q;
        odata_d = debug_data;
        ovld_d  = 1'b1;
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (ovld_q && out_ready) begin
          ovld_d = 1'b0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
          sum_d  = sum_q + odata_q;
`endif
          // Compare before incrementing so a window ending at the top address never wraps.
          if (addr_q == LAST_A) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
`ifdef DEBUG_SCAN_CHECKSUM_EN
            sum_vld_d = 1'b1;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        addr_d  = FIRST_A;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= FIRST_A;
      oaddr_q     <= '0;
      odata_q     <= '0;
      ovld_q      <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_step_q <= 1'b0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
      sum_q       <= '0;
      sum_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      oaddr_q     <= oaddr_d;
      odata_q     <= odata_d;
      ovld_q      <= ovld_d;
      step_q      <= step_d;
      done_q      <= done_d;
      en_q        <= en_d;
      pend_q      <= pend_d;
      pend_step_q <= pend_step_d;
`ifdef DEBUG_SCAN_CHECKSUM_EN
      sum_q       <= sum_d;
      sum_vld_q   <= sum_vld_d;
`endif
    end
  end

  assign debug_en   = en_q;
  assign debug_step = step_q;
  assign debug_addr = addr_q;
  assign out_valid  = ovld_q;
  assign out_addr   = oaddr_q;
  assign out_data   = odata_q;
  assign busy       = (state_q != ST_IDLE);
  assign scan_done  = done_q;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  assign scan_sum   = sum_q;
  assign sum_valid  = sum_vld_q;
`endif

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Directed/randomized bench for debug_scan_ctrl with a word-sequence reference model.
module tb_debug_scan_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int FIRST = 0;
  localparam int LAST  = 3;
  localparam int SET   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_mode, step_req, scan_req, out_ready;
  logic          debug_en, debug_step, out_valid, busy, scan_done;
  logic [AW-1:0] debug_addr, out_addr;
  logic [DW-1:0] debug_data, out_data;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  logic [DW-1:0] scan_sum;
  logic          sum_valid;
`endif

  logic [DW-1:0] mem [4];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign debug_data = mem[debug_addr];

  debug_scan_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .SCAN_FIRST(FIRST), .SCAN_LAST(LAST), .SETTLE(SET)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_mode   (run_mode),
    .step_req   (step_req),
    .scan_req   (scan_req),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .debug_addr (debug_addr),
    .debug_data (debug_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .scan_done  (scan_done)
`ifdef DEBUG_SCAN_CHECKSUM_EN
    ,
    .scan_sum   (scan_sum),
    .sum_valid  (sum_valid)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
  endtask

  // trig: 0 step edge, 1 scan_req, 2 pending step from previous sweep, 3 step+scan together
  task automatic sweep(input int trig, input int stall_addr, input int stall_n,
                       input int inj_a, input int inj_b);
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] exp_d;
    int wait_n, exp_lat;
    bit stepped;
    exp_sum = '0;
    stepped = (trig != 1) && !run_mode;
    if (trig == 0 || trig == 3) step_req = 1'b1;
    if (trig == 1 || trig == 3) scan_req = 1'b1;
    tick();
    step_req = 1'b0;
    scan_req = 1'b0;
    chk("busy_start", busy, 1);
    chk("step_pulse", debug_step, stepped);
    for (int a = FIRST; a <= LAST; a++) begin
      wait_n = 0;
      while (!out_valid && wait_n < 20) begin
        tick();
        wait_n++;
      end
      exp_lat = (a == FIRST) ? ((stepped ? 1 : 0) + SET + 1) : (SET + 1);
      chk("latency", wait_n, exp_lat);
      chk("step_once", debug_step, 0);
      exp_d = mem[a];
      chk("out_addr", out_addr, a);
      chk("out_data", out_data, exp_d);
      if (a == stall_addr) begin
        out_ready = 1'b0;
        mem[a] = ~mem[a];
        repeat (stall_n) begin
          tick();
          chk("stall_valid", out_valid, 1);
          chk("stall_addr", out_addr, a);
          chk("stall_data", out_data, exp_d);
        end
        out_ready = 1'b1;
      end
      if (a == inj_a || a == inj_b) step_req = 1'b1;
      exp_sum = exp_sum + exp_d;
      tick();
      step_req = 1'b0;
      chk("valid_drop", out_valid, 0);
      chk("scan_done", scan_done, (a == LAST) ? 1 : 0);
    end
`ifdef DEBUG_SCAN_CHECKSUM_EN
    chk("scan_sum", scan_sum, exp_sum);
    chk("sum_valid", sum_valid, 1);
`endif
    tick();
    chk("done_once", scan_done, 0);
    chk("idle_busy", busy, 0);
    chk("addr_home", debug_addr, FIRST);
`ifdef DEBUG_SCAN_CHECKSUM_EN
    chk("sum_valid_once", sum_valid, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wn;
    rst = 1'b0; run_mode = 1'b0; step_req = 1'b0; scan_req = 1'b0; out_ready = 1'b1;
    rand_mem();
    #3;
    chk("rst_en", debug_en, 0);
    chk("rst_step", debug_step, 0);
    chk("rst_addr", debug_addr, FIRST);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", scan_done, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("en_halt", debug_en, 1);

    // T2 plain step sweep, then a step and scan in the same cycle
    rand_mem();
    sweep(0, -1, 0, -1, -1);
    rand_mem();
    sweep(3, -1, 0, -1, -1);

    // T3 backpressure on address 2
    rand_mem();
    sweep(0, 2, 5, -1, -1);

    // T4 pending step serviced after DONE; second in-scan edge dropped
    rand_mem();
    sweep(0, -1, 0, 1, 2);
    rand_mem();
    sweep(2, -1, 0, -1, -1);
    repeat (3) tick();
    chk("t4_dropped", busy, 0);

    // T5 run mode: steps ignored, scans still sweep
    run_mode = 1'b1;
    tick();
    chk("t5_en", debug_en, 0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("t5_nostep", debug_step, 0);
    tick();
    chk("t5_idle", busy, 0);
    rand_mem();
    sweep(1, -1, 0, -1, -1);
    run_mode = 1'b0;
    tick();

    // T1 asynchronous reset while PUSH holds a word, with a pending request
    out_ready = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    wn = 0;
    while (!out_valid && wn < 20) begin
      tick();
      wn++;
    end
    chk("t1_push", out_valid, 1);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("t1_valid", out_valid, 0);
    chk("t1_oaddr", out_addr, 0);
    chk("t1_odata", out_data, 0);
    chk("t1_busy", busy, 0);
    chk("t1_addr", debug_addr, FIRST);
    chk("t1_en", debug_en, 0);
    chk("t1_done", scan_done, 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("t1_nopend", busy, 0);
    end

`ifdef DEBUG_SCAN_CHECKSUM_EN
    // T6 checksum wraps modulo 2^32
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd1; mem[2] = 32'd2; mem[3] = 32'd3;
    sweep(1, -1, 0, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
